// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_types_pkg
//  Brief    : Base RV32I word type and architectural reset constants.
//  Revision : 1.0  initial release
// ============================================================================
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t c_reset_pc = 32'h0000_0200;

endpackage
`default_nettype wire

// File: rtl/stage5_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stage5_pkg
//  Brief    : Shared types for the five-stage pipeline (IF/DC latch bundle).
//  Revision : 1.0  initial release
// ============================================================================
package stage5_pkg;

    import rv32i_types_pkg::*;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  pred_taken;
        logic  fault_insn;
        logic  mal_insn;
    } fd_latch_t;

    localparam fd_latch_t c_fd_reset = '0;

endpackage
`default_nettype wire

// File: rtl/stage5_npc_mux.sv
`default_nettype none
// ============================================================================
//  Module   : stage5_npc_mux
//  Brief    : Combinational next-PC priority select for the fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
module stage5_npc_mux
    import rv32i_types_pkg::*;
(
    input  word_t pc,
    input  logic  insert_priv_pc,
    input  word_t priv_pc,
    input  logic  rollback,
    input  word_t rollback_addr,
    input  logic  npc_sel,
    input  word_t brj_addr,
    input  logic  predict_taken,
    input  word_t predict_target,
    output word_t npc,
    output logic  redirect
);

    assign redirect = insert_priv_pc | rollback | npc_sel;

    // Trap/xRET beats rollback beats resolved branch beats prediction.
    always_comb begin
        npc = pc + 32'd4;
        if (insert_priv_pc) begin
            npc = priv_pc;
        end else if (rollback) begin
            npc = rollback_addr;
        end else if (npc_sel) begin
            npc = brj_addr;
        end else if (predict_taken) begin
            npc = predict_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage5_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : stage5_fetch_stage
//  Brief    : Instruction fetch stage: PC, imem request, deferred redirect
//             buffer and the IF/DC pipeline latch.
//  Revision : 1.0  initial release
// ============================================================================
module stage5_fetch_stage
    import rv32i_types_pkg::*;
    import stage5_pkg::*;
#(
    parameter word_t RESET_PC = c_reset_pc
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic        insert_priv_pc,
    input  logic [31:0] priv_pc,
    input  logic        rollback,
    input  logic [31:0] rollback_addr,
    input  logic [31:0] brj_addr,
    input  logic        predict_taken,
    input  logic [31:0] predict_target,
    input  logic        iren,
    input  logic        suppress_iren,
    input  logic        if_dc_stall,
    input  logic        if_dc_flush,
    output logic        i_mem_busy,
    output logic [31:0] pc_f,
    output logic [31:0] fault_addr_fetch,
    output logic [31:0] imem_addr,
    output logic        imem_ren,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    output logic        fd_valid,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_pc4,
    output logic        fd_pred_taken,
    output logic        fd_fault_insn,
    output logic        fd_mal_insn
);

    word_t     r_pc;
    word_t     r_redirect_target;
    logic      r_redirect_pending;
    word_t     r_fault_addr;
    fd_latch_t r_fd;

    word_t     w_npc;
    word_t     w_pc4;
    logic      w_redirect;
    logic      w_misaligned;
    logic      w_fetch_req;
    logic      w_imem_ren;
    logic      w_fetch_done;
    logic      w_mis_fetch;
    fd_latch_t w_fd_next;

    stage5_npc_mux u_npc_mux (
        .pc             (r_pc),
        .insert_priv_pc (insert_priv_pc),
        .priv_pc        (priv_pc),
        .rollback       (rollback),
        .rollback_addr  (rollback_addr),
        .npc_sel        (npc_sel),
        .brj_addr       (brj_addr),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .npc            (w_npc),
        .redirect       (w_redirect)
    );

    assign w_pc4        = r_pc + 32'd4;
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_fetch_req  = iren & ~suppress_iren;
    // The bus is never driven from a misaligned PC or while a redirect waits.
    assign w_imem_ren   = w_fetch_req & ~w_misaligned & ~r_redirect_pending & ~nRST;
    assign w_fetch_done = w_imem_ren & ~imem_busy;
    assign w_mis_fetch  = w_fetch_req & w_misaligned & ~r_redirect_pending;

    always_comb begin
        w_fd_next = r_fd;
        if (if_dc_flush) begin
            w_fd_next.valid = 1'b0;
        end else if (!if_dc_stall) begin
            w_fd_next.valid      = w_fetch_done | w_mis_fetch;
            w_fd_next.instr      = ((w_fetch_done & imem_error) | w_misaligned) ? '0 : imem_rdata;
            w_fd_next.pc         = r_pc;
            w_fd_next.pc4        = w_pc4;
            w_fd_next.pred_taken = predict_taken;
            w_fd_next.fault_insn = w_fetch_done & imem_error;
            w_fd_next.mal_insn   = w_misaligned;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_pc               <= RESET_PC;
            r_redirect_pending <= 1'b0;
            r_redirect_target  <= '0;
            r_fault_addr       <= '0;
            r_fd               <= c_fd_reset;
        end else begin
            r_fd <= w_fd_next;
            if (w_mis_fetch | (w_fetch_done & imem_error)) begin
                r_fault_addr <= r_pc;
            end
            // While a transfer is outstanding the PC (and so imem_addr) is
            // frozen; the redirect is parked and applied once the beat drains.
            if (r_redirect_pending) begin
                if (!imem_busy) begin
                    r_pc               <= w_redirect ? w_npc : r_redirect_target;
                    r_redirect_pending <= 1'b0;
                end else if (w_redirect) begin
                    r_redirect_target <= w_npc;
                end
            end else if (w_redirect) begin
                if (imem_busy) begin
                    r_redirect_pending <= 1'b1;
                    r_redirect_target  <= w_npc;
                end else begin
                    r_pc <= w_npc;
                end
            end else if (pc_en) begin
                r_pc <= w_npc;
            end
        end
    end

    assign pc_f             = r_pc;
    assign imem_addr        = r_pc;
    assign imem_ren         = w_imem_ren;
    assign i_mem_busy       = imem_busy | r_redirect_pending;
    assign fault_addr_fetch = r_fault_addr;
    assign fd_valid         = r_fd.valid;
    assign fd_instr         = r_fd.instr;
    assign fd_pc            = r_fd.pc;
    assign fd_pc4           = r_fd.pc4;
    assign fd_pred_taken    = r_fd.pred_taken;
    assign fd_fault_insn    = r_fd.fault_insn;
    assign fd_mal_insn      = r_fd.mal_insn;

endmodule
`default_nettype wire

// File: tb/tb_stage5_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage5_fetch_stage
//  Brief    : Self-checking bench for stage5_fetch_stage (directed + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stage5_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST, pc_en, npc_sel, insert_priv_pc, rollback, predict_taken;
    logic        iren, suppress_iren, if_dc_stall, if_dc_flush;
    logic [31:0] priv_pc, rollback_addr, brj_addr, predict_target;
    logic        i_mem_busy, imem_ren, imem_busy, imem_error;
    logic [31:0] pc_f, fault_addr_fetch, imem_addr, imem_rdata;
    logic        fd_valid, fd_pred_taken, fd_fault_insn, fd_mal_insn;
    logic [31:0] fd_instr, fd_pc, fd_pc4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    stage5_fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .npc_sel(npc_sel),
        .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc),
        .rollback(rollback), .rollback_addr(rollback_addr),
        .brj_addr(brj_addr), .predict_taken(predict_taken),
        .predict_target(predict_target), .iren(iren),
        .suppress_iren(suppress_iren), .if_dc_stall(if_dc_stall),
        .if_dc_flush(if_dc_flush), .i_mem_busy(i_mem_busy), .pc_f(pc_f),
        .fault_addr_fetch(fault_addr_fetch), .imem_addr(imem_addr),
        .imem_ren(imem_ren), .imem_busy(imem_busy), .imem_rdata(imem_rdata),
        .imem_error(imem_error), .fd_valid(fd_valid), .fd_instr(fd_instr),
        .fd_pc(fd_pc), .fd_pc4(fd_pc4), .fd_pred_taken(fd_pred_taken),
        .fd_fault_insn(fd_fault_insn), .fd_mal_insn(fd_mal_insn)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        pc_en = 0; npc_sel = 0; insert_priv_pc = 0; rollback = 0;
        predict_taken = 0; iren = 1; suppress_iren = 0;
        if_dc_stall = 0; if_dc_flush = 0; imem_busy = 0; imem_error = 0;
        priv_pc = 0; rollback_addr = 0; brj_addr = 0; predict_target = 0;
        imem_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1;
        tick(); tick();
        total_cnt++; if (pc_f !== 32'h200) $display("FAIL reset_pc got %h exp %h", pc_f, 32'h200); else pass_cnt++;
        total_cnt++; if (imem_ren !== 1'b0) $display("FAIL reset_ren got %b exp 0", imem_ren); else pass_cnt++;
        total_cnt++; if (fd_valid !== 1'b0) $display("FAIL reset_fd_valid got %b exp 0", fd_valid); else pass_cnt++;
        total_cnt++; if (fd_instr !== 32'h0 || fd_pc !== 32'h0) $display("FAIL reset_fd_fields got %h/%h exp 0/0", fd_instr, fd_pc); else pass_cnt++;
        total_cnt++; if (fault_addr_fetch !== 32'h0) $display("FAIL reset_fault got %h exp 0", fault_addr_fetch); else pass_cnt++;
        total_cnt++; if (i_mem_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", i_mem_busy); else pass_cnt++;
    endtask

    task automatic test_seq_fetch();
        nRST = 0; pc_en = 1; imem_rdata = 32'h0000_0013;
        #1;
        total_cnt++; if (imem_addr !== 32'h200) $display("FAIL seq_addr got %h exp %h", imem_addr, 32'h200); else pass_cnt++;
        total_cnt++; if (imem_ren !== 1'b1) $display("FAIL seq_ren got %b exp 1", imem_ren); else pass_cnt++;
        tick();
        total_cnt++; if (fd_valid !== 1'b1) $display("FAIL seq_fd_valid got %b exp 1", fd_valid); else pass_cnt++;
        total_cnt++; if (fd_pc !== 32'h200) $display("FAIL seq_fd_pc got %h exp %h", fd_pc, 32'h200); else pass_cnt++;
        total_cnt++; if (fd_instr !== 32'h13) $display("FAIL seq_fd_instr got %h exp %h", fd_instr, 32'h13); else pass_cnt++;
        total_cnt++; if (fd_pc4 !== 32'h204) $display("FAIL seq_fd_pc4 got %h exp %h", fd_pc4, 32'h204); else pass_cnt++;
        total_cnt++; if (pc_f !== 32'h204) $display("FAIL seq_pc got %h exp %h", pc_f, 32'h204); else pass_cnt++;
        imem_rdata = 32'h0000_0033;
        tick();
        total_cnt++; if (pc_f !== 32'h208 || fd_pc !== 32'h204) $display("FAIL seq_pc2 got %h/%h exp 208/204", pc_f, fd_pc); else pass_cnt++;
    endtask

    task automatic test_deferred_redirect();
        pc_en = 0; imem_busy = 1; npc_sel = 1; brj_addr = 32'h400;
        #1;
        total_cnt++; if (imem_addr !== 32'h208) $display("FAIL defer_addr0 got %h exp %h", imem_addr, 32'h208); else pass_cnt++;
        total_cnt++; if (i_mem_busy !== 1'b1) $display("FAIL defer_busy0 got %b exp 1", i_mem_busy); else pass_cnt++;
        tick();
        npc_sel = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++; if (imem_addr !== 32'h208) $display("FAIL defer_addr got %h exp %h", imem_addr, 32'h208); else pass_cnt++;
            total_cnt++; if (i_mem_busy !== 1'b1) $display("FAIL defer_busy got %b exp 1", i_mem_busy); else pass_cnt++;
            total_cnt++; if (imem_ren !== 1'b0) $display("FAIL defer_ren got %b exp 0", imem_ren); else pass_cnt++;
            tick();
        end
        imem_busy = 0;
        #1;
        total_cnt++; if (i_mem_busy !== 1'b1 || imem_addr !== 32'h208) $display("FAIL defer_drain got %b/%h exp 1/208", i_mem_busy, imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (fd_valid !== 1'b0) $display("FAIL defer_dropped got %b exp 0", fd_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h400) $display("FAIL defer_target got %h exp %h", imem_addr, 32'h400); else pass_cnt++;
        total_cnt++; if (i_mem_busy !== 1'b0 || imem_ren !== 1'b1) $display("FAIL defer_after got %b/%b exp 0/1", i_mem_busy, imem_ren); else pass_cnt++;
    endtask

    task automatic test_priority();
        insert_priv_pc = 1; priv_pc = 32'h100; rollback = 1; rollback_addr = 32'h500;
        npc_sel = 1; brj_addr = 32'h400; pc_en = 1; predict_taken = 1; predict_target = 32'h700;
        tick();
        total_cnt++; if (pc_f !== 32'h100) $display("FAIL prio_priv got %h exp %h", pc_f, 32'h100); else pass_cnt++;
        insert_priv_pc = 0;
        tick();
        total_cnt++; if (pc_f !== 32'h500) $display("FAIL prio_rollback got %h exp %h", pc_f, 32'h500); else pass_cnt++;
        rollback = 0;
        tick();
        total_cnt++; if (pc_f !== 32'h400) $display("FAIL prio_brj got %h exp %h", pc_f, 32'h400); else pass_cnt++;
        npc_sel = 0;
        tick();
        total_cnt++; if (pc_f !== 32'h700 || fd_pred_taken !== 1'b1) $display("FAIL prio_pred got %h/%b exp 700/1", pc_f, fd_pred_taken); else pass_cnt++;
        predict_taken = 0; pc_en = 0;
        tick();
        total_cnt++; if (pc_f !== 32'h700) $display("FAIL prio_hold got %h exp %h", pc_f, 32'h700); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        npc_sel = 1; brj_addr = 32'h202;
        tick();
        npc_sel = 0; imem_rdata = 32'hABCD_0001;
        #1;
        total_cnt++; if (imem_ren !== 1'b0) $display("FAIL mis_ren got %b exp 0", imem_ren); else pass_cnt++;
        tick();
        total_cnt++; if (fd_valid !== 1'b1 || fd_mal_insn !== 1'b1) $display("FAIL mis_fd got %b/%b exp 1/1", fd_valid, fd_mal_insn); else pass_cnt++;
        total_cnt++; if (fd_instr !== 32'h0) $display("FAIL mis_instr got %h exp 0", fd_instr); else pass_cnt++;
        total_cnt++; if (fault_addr_fetch !== 32'h202) $display("FAIL mis_fault got %h exp %h", fault_addr_fetch, 32'h202); else pass_cnt++;
    endtask

    task automatic test_fetch_fault();
        npc_sel = 1; brj_addr = 32'h300;
        tick();
        npc_sel = 0; imem_error = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        total_cnt++; if (fd_valid !== 1'b1 || fd_fault_insn !== 1'b1) $display("FAIL flt_fd got %b/%b exp 1/1", fd_valid, fd_fault_insn); else pass_cnt++;
        total_cnt++; if (fd_instr !== 32'h0 || fd_mal_insn !== 1'b0) $display("FAIL flt_instr got %h/%b exp 0/0", fd_instr, fd_mal_insn); else pass_cnt++;
        total_cnt++; if (fault_addr_fetch !== 32'h300) $display("FAIL flt_addr got %h exp %h", fault_addr_fetch, 32'h300); else pass_cnt++;
        imem_error = 0;
    endtask

    task automatic test_stall_flush();
        imem_rdata = 32'h11; if_dc_stall = 1; if_dc_flush = 1;
        tick();
        total_cnt++; if (fd_valid !== 1'b0) $display("FAIL flush_wins got %b exp 0", fd_valid); else pass_cnt++;
        if_dc_stall = 0; if_dc_flush = 0;
        tick();
        total_cnt++; if (fd_valid !== 1'b1 || fd_instr !== 32'h11) $display("FAIL reload got %b/%h exp 1/11", fd_valid, fd_instr); else pass_cnt++;
        if_dc_stall = 1; imem_rdata = 32'h22; pc_en = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++; if (fd_valid !== 1'b1 || fd_instr !== 32'h11 || fd_pc !== 32'h300) $display("FAIL stall_hold got %b/%h/%h exp 1/11/300", fd_valid, fd_instr, fd_pc); else pass_cnt++;
        end
        total_cnt++; if (pc_f !== 32'h308) $display("FAIL stall_pc got %h exp %h", pc_f, 32'h308); else pass_cnt++;
        if_dc_stall = 0; pc_en = 0;
    endtask

    task automatic test_wraparound();
        npc_sel = 1; brj_addr = 32'hFFFF_FFFC;
        tick();
        npc_sel = 0; pc_en = 1;
        tick();
        total_cnt++; if (pc_f !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc_f); else pass_cnt++;
        total_cnt++; if (fd_pc !== 32'hFFFF_FFFC || fd_pc4 !== 32'h0) $display("FAIL wrap_fd got %h/%h exp fffffffc/0", fd_pc, fd_pc4); else pass_cnt++;
        pc_en = 0;
    endtask

    task automatic test_reset_mid_transfer();
        imem_busy = 1; npc_sel = 1; brj_addr = 32'h400;
        tick();
        npc_sel = 0; nRST = 1;
        #1;
        total_cnt++; if (imem_ren !== 1'b0) $display("FAIL rstmid_ren got %b exp 0", imem_ren); else pass_cnt++;
        tick();
        imem_busy = 0;
        #1;
        total_cnt++; if (pc_f !== 32'h200 || i_mem_busy !== 1'b0) $display("FAIL rstmid_state got %h/%b exp 200/0", pc_f, i_mem_busy); else pass_cnt++;
        nRST = 0; imem_rdata = 32'h55;
        tick();
        total_cnt++; if (fd_valid !== 1'b1 || fd_pc !== 32'h200 || pc_f !== 32'h200) $display("FAIL rstmid_fetch got %b/%h/%h exp 1/200/200", fd_valid, fd_pc, pc_f); else pass_cnt++;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'h0000_FFFC;
        if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Reference model: architectural PC, parked redirect, fault register and latch.
    task automatic test_random();
        logic [31:0] m_pc, m_tgt, m_fault, m_instr, m_fpc, m_fpc4, nxt;
        logic        m_pend, m_v, m_pred, m_fi, m_mi;
        logic        mis, want, exp_ren, done, mis_fetch, redir;
        clear_inputs();
        nRST = 1;
        tick();
        m_pc = 32'h200; m_tgt = 0; m_pend = 0; m_fault = 0;
        m_v = 0; m_instr = 0; m_fpc = 0; m_fpc4 = 0; m_pred = 0; m_fi = 0; m_mi = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nRST           = ($urandom_range(0, 99) == 0);
            pc_en          = ($urandom_range(0, 3) != 0);
            insert_priv_pc = ($urandom_range(0, 19) == 0);
            rollback       = ($urandom_range(0, 19) == 0);
            npc_sel        = ($urandom_range(0, 9) == 0);
            priv_pc = rand_addr(); rollback_addr = rand_addr(); brj_addr = rand_addr();
            predict_taken  = ($urandom_range(0, 3) == 0);
            predict_target = rand_addr();
            iren           = ($urandom_range(0, 7) != 0);
            suppress_iren  = ($urandom_range(0, 9) == 0);
            if_dc_stall    = ($urandom_range(0, 7) == 0);
            if_dc_flush    = ($urandom_range(0, 15) == 0);
            imem_busy      = ($urandom_range(0, 2) == 0);
            imem_error     = ($urandom_range(0, 15) == 0);
            imem_rdata     = $urandom;
            #1;
            mis     = (m_pc % 4) != 0;
            want    = iren && !suppress_iren;
            exp_ren = !nRST && want && !mis && !m_pend;
            total_cnt++; if (imem_addr !== m_pc || imem_ren !== exp_ren) $display("FAIL rnd_bus cyc %0d got %h/%b exp %h/%b", cyc, imem_addr, imem_ren, m_pc, exp_ren); else pass_cnt++;
            total_cnt++; if (i_mem_busy !== (imem_busy || m_pend)) $display("FAIL rnd_ibusy cyc %0d got %b exp %b", cyc, i_mem_busy, imem_busy || m_pend); else pass_cnt++;
            redir = insert_priv_pc || rollback || npc_sel;
            if (insert_priv_pc) nxt = priv_pc;
            else if (rollback) nxt = rollback_addr;
            else if (npc_sel) nxt = brj_addr;
            else if (predict_taken) nxt = predict_target;
            else nxt = m_pc + 4;
            if (nRST) begin
                m_pc = 32'h200; m_tgt = 0; m_pend = 0; m_fault = 0;
                m_v = 0; m_instr = 0; m_fpc = 0; m_fpc4 = 0; m_pred = 0; m_fi = 0; m_mi = 0;
            end else begin
                done      = exp_ren && !imem_busy;
                mis_fetch = want && mis && !m_pend;
                if (mis_fetch || (done && imem_error)) m_fault = m_pc;
                if (if_dc_flush) m_v = 0;
                else if (!if_dc_stall) begin
                    m_v = done || mis_fetch;
                    m_instr = (imem_error || mis) ? 32'h0 : imem_rdata;
                    m_fpc = m_pc; m_fpc4 = m_pc + 4; m_pred = predict_taken;
                    m_fi = done && imem_error; m_mi = mis;
                end
                if (m_pend) begin
                    if (!imem_busy) begin m_pc = redir ? nxt : m_tgt; m_pend = 0; end
                    else if (redir) m_tgt = nxt;
                end else if (redir) begin
                    if (imem_busy) begin m_pend = 1; m_tgt = nxt; end
                    else m_pc = nxt;
                end else if (pc_en) m_pc = nxt;
            end
            tick();
            total_cnt++; if (pc_f !== m_pc) $display("FAIL rnd_pc cyc %0d got %h exp %h", cyc, pc_f, m_pc); else pass_cnt++;
            total_cnt++; if (fault_addr_fetch !== m_fault) $display("FAIL rnd_fault cyc %0d got %h exp %h", cyc, fault_addr_fetch, m_fault); else pass_cnt++;
            total_cnt++; if (fd_valid !== m_v) $display("FAIL rnd_fd_valid cyc %0d got %b exp %b", cyc, fd_valid, m_v); else pass_cnt++;
            if (m_v) begin
                total_cnt++;
                if (fd_instr !== m_instr || fd_pc !== m_fpc || fd_pc4 !== m_fpc4 ||
                    fd_pred_taken !== m_pred || fd_fault_insn !== m_fi || fd_mal_insn !== m_mi)
                    $display("FAIL rnd_fd cyc %0d got %h/%h/%h/%b%b%b exp %h/%h/%h/%b%b%b", cyc,
                             fd_instr, fd_pc, fd_pc4, fd_pred_taken, fd_fault_insn, fd_mal_insn,
                             m_instr, m_fpc, m_fpc4, m_pred, m_fi, m_mi);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        clear_inputs();
        nRST = 1;
        #2;
        test_reset();
        test_seq_fetch();
        test_deferred_redirect();
        test_priority();
        test_misaligned();
        test_fetch_fault();
        test_stall_flush();
        test_wraparound();
        test_reset_mid_transfer();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage5_fetch_stage.md
Name: stage5_fetch_stage

Overview:
- Instruction-fetch stage of the five-stage pipeline; sits directly upstream of decode and is steered by the stage-5 hazard unit.
- Owns the PC register and the instruction-memory request.
- Holds a one-entry deferred-redirect buffer so that a redirect arriving mid-transfer is applied cleanly.
- Produces the IF/DC pipeline latch (instruction, PC, prediction, fetch faults) consumed by decode.

Parameters:
RESET_PC, 32'h0000_0200, PC value loaded on reset.

Ports:
CLK  in  1  clock
nRST  in  1  reset; synchronous, active-high (asserted = 1) despite the conventional name
pc_en  in  1  hazard unit: advance PC this cycle
npc_sel  in  1  hazard unit: take resolved branch/jump target
insert_priv_pc  in  1  hazard unit: redirect to trap/xRET vector
priv_pc  in  32  trap/xRET target
rollback  in  1  hazard unit: refetch from rollback_addr
rollback_addr  in  32  PC following the instruction in mem stage
brj_addr  in  32  resolved branch/jump target from execute
predict_taken  in  1  predictor lookup result for pc_f
predict_target  in  32  predicted target for pc_f
iren  in  1  hazard unit: fetch permitted
suppress_iren  in  1  hazard unit: inhibit new fetch
if_dc_stall  in  1  hold IF/DC latch
if_dc_flush  in  1  clear IF/DC latch valid
i_mem_busy  out  1  to hazard unit: imem_busy OR redirect_pending
pc_f  out  32  current fetch PC
fault_addr_fetch  out  32  PC of the faulting fetch
imem_addr  out  32  instruction bus address
imem_ren  out  1  instruction bus read enable
imem_busy  in  1  bus transfer not yet complete
imem_rdata  in  32  bus read data
imem_error  in  1  bus access fault, valid with the completing beat
fd_valid  out  1  IF/DC: entry valid
fd_instr  out  32  IF/DC: instruction word
fd_pc  out  32  IF/DC: instruction PC
fd_pc4  out  32  IF/DC: PC+4
fd_pred_taken  out  1  IF/DC: prediction used
fd_fault_insn  out  1  IF/DC: access fault
fd_mal_insn  out  1  IF/DC: misaligned fetch

Behaviour:
- Reset (nRST=1 at CLK edge): pc=RESET_PC, redirect_pending=0, redirect_target=0, all fd_* = 0, fault_addr_fetch=0. imem_ren is forced 0 while nRST=1.
- Next-PC priority: insert_priv_pc > rollback > npc_sel > predict_taken > pc+4, with 32-bit wraparound (pc+4 from 32'hFFFF_FFFC yields 0).
- imem_addr = pc; pc_f = pc.
- imem_ren = iren & ~suppress_iren & ~misaligned & ~redirect_pending, where misaligned = (pc[1:0] != 0).
- A fetch completes in a cycle where imem_ren=1 and imem_busy=0. Minimum latency is 1 cycle, request to IF/DC latch.
- Redirect (insert_priv_pc | rollback | npc_sel):
  - If imem_busy=0 at the redirect: pc <= target next edge.
  - If imem_busy=1 at the redirect: redirect_pending <= 1 and redirect_target <= target. imem_addr must stay stable, so pc is held. When imem_busy falls, that beat is discarded (no IF/DC load), pc <= redirect_target and redirect_pending <= 0.
  - A newer redirect while already pending overwrites redirect_target (last writer wins, with priority applied within the cycle).
- Sequential advance: when pc_en=1 and no redirect, pc <= predict_taken ? predict_target : pc+4.
- PC is held when neither pc_en nor a redirect is present.
- IF/DC latch:
  - if_dc_flush: fd_valid <= 0, other fields don't-care. Flush wins over stall.
  - Else if_dc_stall: hold all fields.
  - Else load: fd_valid = (fetch completes & not discarded) | (misaligned & iren & ~suppress_iren); fd_instr = imem_rdata (0 on fault or misalign); fd_pc = pc; fd_pc4 = pc+4; fd_pred_taken = predict_taken; fd_fault_insn = imem_error; fd_mal_insn = misaligned.
- Faults: on a misaligned fetch or a completing beat with imem_error=1, fault_addr_fetch <= pc. The register is held otherwise.
- Misaligned fetch issues no bus request and produces the fault entry in the same cycle.
- Reset asserted mid-transfer: state returns to reset values. The bus beat completing afterwards is ignored, because imem_ren=0.

Decomposition:
- Shared package rv32i_types_pkg: word_t and the RESET_PC default constant.
- Shared package stage5_pkg: an fd_latch_t struct bundling the fd_* fields.
- One natural sub-module, stage5_npc_mux: the combinational next-PC priority select. All state stays in the top module.

Test Plan:
1. Reset released, iren=1, imem_busy=0, imem_rdata=32'h00000013 -> imem_addr=32'h200 cycle 1; fd_valid=1, fd_pc=32'h200, fd_instr=32'h13 next cycle; pc=32'h204.
2. imem_busy=1 for 3 cycles at pc=32'h208 with npc_sel=1, brj_addr=32'h400 in cycle 1 -> imem_addr stays 32'h208, i_mem_busy=1 throughout; completing beat dropped (fd_valid=0); next imem_addr=32'h400.
3. insert_priv_pc=1, priv_pc=32'h100, with npc_sel=1 and rollback=1 same cycle -> pc=32'h100.
4. brj_addr=32'h202 redirect -> no bus request, fd_valid=1, fd_mal_insn=1, fault_addr_fetch=32'h202.
5. imem_error=1 on completing beat at 32'h300 -> fd_fault_insn=1, fd_instr=0, fault_addr_fetch=32'h300.
6. if_dc_stall=1 and if_dc_flush=1 together with a completing fetch -> fd_valid=0. Stall alone for 2 cycles -> fd_* unchanged.
